// File: rtl/ring_decoder_monitor.sv
// Receive-side monitor for a one-hot ring counter: decodes the ring word, checks
// one-hot validity and rotate-left sequencing, tracks lock and counts errors.
// Optional feature macro: RING_MON_STALL_OK_EN (accept a repeated sample while locked).
module ring_decoder_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned ERR_W    = 8,
  localparam int unsigned IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             sample_en,
  input  logic             clear_err,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             onehot_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               index_valid_q, index_valid_d;
  logic               locked_q, locked_d;
  logic               seq_err_q, seq_err_d;
  logic               onehot_err_q, onehot_err_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic [WIDTH-1:0]   exp_word;
  logic [IDX_W-1:0]   pos;
  logic               is_onehot;
  int unsigned        ones;

  // Population count and position of the (last) set bit of the ring word.
  always_comb begin
    ones = 0;
    pos  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        ones = ones + 1;
        pos  = IDX_W'(i);
      end
    end
    is_onehot = (ones == 1);
  end

  assign exp_word = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};

  // Next-state, tracking and error-pulse logic.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    good_d        = good_q;
    index_d       = index_q;
    index_valid_d = index_valid_q;
    locked_d      = locked_q;
    seq_err_d     = 1'b0;
    onehot_err_d  = 1'b0;

    if (sample_en) begin
      index_valid_d = is_onehot;
      if (is_onehot) begin
        index_d = pos;
      end

      unique case (state_q)
        UNLOCKED: begin
          if (is_onehot) begin
            prev_d  = ring_in;
            good_d  = '0;
            state_d = ACQUIRE;
          end else begin
            onehot_err_d = 1'b1;
          end
        end
        ACQUIRE: begin
          if (!is_onehot) begin
            onehot_err_d = 1'b1;
            good_d       = '0;
            state_d      = UNLOCKED;
          end else if (ring_in == exp_word) begin
            prev_d = ring_in;
            good_d = good_q + GOOD_W'(1);
            if (good_d == GOOD_W'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            // Re-anchor on the new word; mismatches while acquiring are not errors.
            prev_d = ring_in;
            good_d = '0;
          end
        end
        LOCKED: begin
          if (!is_onehot) begin
            onehot_err_d = 1'b1;
            locked_d     = 1'b0;
            good_d       = '0;
            state_d      = UNLOCKED;
          end else if (ring_in == exp_word) begin
            prev_d = ring_in;
`ifdef RING_MON_STALL_OK_EN
          end else if (ring_in == prev_q) begin
            prev_d = prev_q;
`endif
          end else begin
            seq_err_d = 1'b1;
            prev_d    = ring_in;
            good_d    = '0;
            locked_d  = 1'b0;
            state_d   = ACQUIRE;
          end
        end
        default: begin
          state_d  = UNLOCKED;
          locked_d = 1'b0;
          good_d   = '0;
        end
      endcase
    end
  end

  // Saturating error counter; a clear coinciding with an error leaves one count.
  always_comb begin
    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = (seq_err_d || onehot_err_d) ? ERR_W'(1) : '0;
    end else if ((seq_err_d || onehot_err_d) && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= UNLOCKED;
      prev_q        <= '0;
      good_q        <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      seq_err_q     <= 1'b0;
      onehot_err_q  <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      good_q        <= good_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      locked_q      <= locked_d;
      seq_err_q     <= seq_err_d;
      onehot_err_q  <= onehot_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign locked      = locked_q;
  assign seq_err     = seq_err_q;
  assign onehot_err  = onehot_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_ring_decoder_monitor.sv
// Scoreboard bench for ring_decoder_monitor: directed samples push expected outputs,
// a monitor pops and compares one cycle later. Two DUTs: ERR_W=8 and ERR_W=2.
module tb_ring_decoder_monitor;

  typedef struct packed {
    logic [1:0] idx;
    logic       iv;
    logic       lk;
    logic       se;
    logic       oe;
    logic [7:0] ec;
    logic [1:0] ec2;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] ring_in;
  logic       sample_en;
  logic       clear_err;

  logic [1:0] index_a, index_b;
  logic       iv_a, iv_b, lk_a, lk_b, se_a, se_b, oe_a, oe_b;
  logic [7:0] ec_a;
  logic [1:0] ec_b;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  ring_decoder_monitor #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .ring_in(ring_in), .sample_en(sample_en),
    .clear_err(clear_err), .index(index_a), .index_valid(iv_a), .locked(lk_a),
    .seq_err(se_a), .onehot_err(oe_a), .err_count(ec_a)
  );

  ring_decoder_monitor #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .ring_in(ring_in), .sample_en(sample_en),
    .clear_err(clear_err), .index(index_b), .index_valid(iv_b), .locked(lk_b),
    .seq_err(se_b), .onehot_err(oe_b), .err_count(ec_b)
  );

  // Monitor: every edge that consumes a pushed vector is compared 1ns later.
  always @(posedge clk) begin
    exp_t  e;
    exp_t  act;
    string t;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act.idx = index_a; act.iv = iv_a; act.lk = lk_a; act.se = se_a;
      act.oe = oe_a; act.ec = ec_a; act.ec2 = ec_b;
      checks++;
      if (act !== e ||
          {index_b, iv_b, lk_b, se_b, oe_b} !== {e.idx, e.iv, e.lk, e.se, e.oe}) begin
        errors++;
        $display("FAIL %s: got idx=%0d iv=%b lk=%b se=%b oe=%b ec=%0d ec2=%0d (b: %0d %b %b %b %b) want idx=%0d iv=%b lk=%b se=%b oe=%b ec=%0d ec2=%0d",
                 t, act.idx, act.iv, act.lk, act.se, act.oe, act.ec, act.ec2,
                 index_b, iv_b, lk_b, se_b, oe_b,
                 e.idx, e.iv, e.lk, e.se, e.oe, e.ec, e.ec2);
      end
    end
  end

  task automatic stim(input string t, input logic [3:0] r, input logic en, input logic clr,
                      input logic [1:0] idx, input logic iv, input logic lk,
                      input logic se, input logic oe, input int ec, input int ec2);
    exp_t e;
    @(negedge clk);
    ring_in   = r;
    sample_en = en;
    clear_err = clr;
    e.idx = idx; e.iv = iv; e.lk = lk; e.se = se; e.oe = oe;
    e.ec = 8'(ec); e.ec2 = 2'(ec2);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic drain();
    @(negedge clk);
    sample_en = 1'b0;
    clear_err = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic check_zero(input string t);
    checks++;
    if ({index_a, iv_a, lk_a, se_a, oe_a, ec_a, index_b, iv_b, lk_b, se_b, oe_b, ec_b} !== '0) begin
      errors++;
      $display("FAIL %s: got a=%0d%b%b%b%b ec=%0d b=%0d%b%b%b%b ec=%0d want all zero",
               t, index_a, iv_a, lk_a, se_a, oe_a, ec_a, index_b, iv_b, lk_b, se_b, oe_b, ec_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; ring_in = '0; sample_en = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Acquire and lock
    stim("t1_s0001", 4'b0001, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    stim("t1_s0010", 4'b0010, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    stim("t1_s0100", 4'b0100, 1, 0, 2, 1, 1, 0, 0, 0, 0);
    stim("t1_idle",  4'b1111, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    // Wrap
    stim("t2_s1000", 4'b1000, 1, 0, 3, 1, 1, 0, 0, 0, 0);
    stim("t2_s0001", 4'b0001, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    stim("t2_s0010", 4'b0010, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    // Sequence error and relock
    stim("t3_seqerr", 4'b1000, 1, 0, 3, 1, 0, 1, 0, 1, 1);
    stim("t3_pulse1", 4'b1000, 0, 0, 3, 1, 0, 0, 0, 1, 1);
    stim("t3_acq",    4'b0001, 1, 0, 0, 1, 0, 0, 0, 1, 1);
    stim("t3_relock", 4'b0010, 1, 0, 1, 1, 1, 0, 0, 1, 1);
    // Clear, then one-hot errors
    stim("t4_clear",  4'b0000, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    stim("t4_zero",   4'b0000, 1, 0, 1, 0, 0, 0, 1, 1, 1);
    stim("t4_multi",  4'b0110, 1, 0, 1, 0, 0, 0, 1, 2, 2);
    // Saturation of the 2-bit counter, clear with error
    stim("t5_err3",   4'b1111, 1, 0, 1, 0, 0, 0, 1, 3, 3);
    stim("t5_err4",   4'b1111, 1, 0, 1, 0, 0, 0, 1, 4, 3);
    stim("t5_err5",   4'b1111, 1, 0, 1, 0, 0, 0, 1, 5, 3);
    stim("t5_clr_err",4'b0000, 1, 1, 1, 0, 0, 0, 1, 1, 1);
    stim("t5_clr",    4'b0000, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    // Lock at 0100 then repeat 0100
    stim("t6_s0100",  4'b0100, 1, 0, 2, 1, 0, 0, 0, 0, 0);
    stim("t6_s1000",  4'b1000, 1, 0, 3, 1, 0, 0, 0, 0, 0);
    stim("t6_s0001",  4'b0001, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    stim("t6_s0010",  4'b0010, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    stim("t6_lk0100", 4'b0100, 1, 0, 2, 1, 1, 0, 0, 0, 0);
`ifdef RING_MON_STALL_OK_EN
    stim("t6_stall",  4'b0100, 1, 0, 2, 1, 1, 0, 0, 0, 0);
    stim("t6_after",  4'b1000, 1, 0, 3, 1, 1, 0, 0, 0, 0);
`else
    stim("t6_stall",  4'b0100, 1, 0, 2, 1, 0, 1, 0, 1, 1);
    stim("t6_after",  4'b1000, 1, 0, 3, 1, 0, 0, 0, 1, 1);
`endif
    drain();

    // Asynchronous reset away from the clock edge
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    stim("post_reset", 4'b0010, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
